// File: rtl/ahb2apb_bridge_param_if.sv
// Bus bundle between the AHB-Lite master, the bridge and the APB slaves.
// The slave modport is the bridge's view; the master modport is the environment's view.

interface ahb2apb_bridge_param_if #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_SLV = 3
);

  // AHB side
  logic                   hwrite;
  logic                   hreadyin;
  logic [1:0]             htrans;
  logic [AW-1:0]          haddr;
  logic [DW-1:0]          hwdata;
  logic                   hreadyout;
  logic [1:0]             hresp;
  logic [DW-1:0]          hrdata;

  // APB side
  logic [NUM_SLV-1:0]     psel;
  logic                   penable;
  logic                   pwrite;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata;
  logic [NUM_SLV*DW-1:0]  prdata;
  logic [NUM_SLV-1:0]     pready;
  logic [NUM_SLV-1:0]     pslverr;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata,
    output hreadyout, hresp, hrdata,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata,
    input  hreadyout, hresp, hrdata,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite slave to APB master bridge with region decode over NUM_SLV one-hot APB selects.
// Define AHB2APB_SLVERR_EN to map pslverr and decode misses onto a two-cycle AHB ERROR.

module ahb2apb_bridge_param #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned NUM_SLV     = 3,
  parameter int unsigned REGION_LSB  = 24,
  parameter int unsigned BASE_REGION = 32'h80
) (
  input logic                   i_hclk,
  input logic                   i_hreset,
  ahb2apb_bridge_param_if.slave bus
);

  localparam int unsigned RW = AW - REGION_LSB;
  localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [1:0] HrespOkay = 2'b00;
`ifdef AHB2APB_SLVERR_EN
  localparam logic [1:0] HrespErr  = 2'b01;
`endif

`ifdef AHB2APB_SLVERR_EN
  typedef enum logic [2:0] {
    StIdle, StLatch, StSetup, StAccess, StErr1, StErr2
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle, StLatch, StSetup, StAccess
  } state_e;
`endif

  state_e             r_state,     w_state_d;
  logic [AW-1:0]      r_addr,      w_addr_d;
  logic               r_write,     w_write_d;
  logic               r_hit,       w_hit_d;
  logic [IW-1:0]      r_idx,       w_idx_d;
  logic               r_hreadyout, w_hreadyout_d;
  logic [1:0]         r_hresp,     w_hresp_d;
  logic [DW-1:0]      r_hrdata,    w_hrdata_d;
  logic [NUM_SLV-1:0] r_psel,      w_psel_d;
  logic               r_penable,   w_penable_d;
  logic               r_pwrite,    w_pwrite_d;
  logic [AW-1:0]      r_paddr,     w_paddr_d;
  logic [DW-1:0]      r_pwdata,    w_pwdata_d;

  logic [RW-1:0]      w_region;
  logic               w_dec_hit;
  logic [IW-1:0]      w_dec_idx;
  logic               w_valid;
  logic               w_sel_pready;
  logic [DW-1:0]      w_sel_prdata;
`ifdef AHB2APB_SLVERR_EN
  logic               w_sel_pslverr;
`else
  logic               w_unused_pslverr;
  assign w_unused_pslverr = ^bus.pslverr;
`endif

  // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY never start a transfer.
  assign w_valid  = bus.hreadyin & r_hreadyout & bus.htrans[1];
  assign w_region = bus.haddr[AW-1:REGION_LSB];

  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (w_region == RW'(BASE_REGION + i)) begin
        w_dec_hit = 1'b1;
        w_dec_idx = IW'(i);
      end
    end
  end

  // Only the latched slave's response lines are looked at.
  always_comb begin
    w_sel_pready  = 1'b0;
    w_sel_prdata  = '0;
`ifdef AHB2APB_SLVERR_EN
    w_sel_pslverr = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_pready  = bus.pready[i];
        w_sel_prdata  = bus.prdata[i*DW +: DW];
`ifdef AHB2APB_SLVERR_EN
        w_sel_pslverr = bus.pslverr[i];
`endif
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_write_d     = r_write;
    w_hit_d       = r_hit;
    w_idx_d       = r_idx;
    w_hreadyout_d = r_hreadyout;
    w_hresp_d     = r_hresp;
    w_hrdata_d    = r_hrdata;
    w_psel_d      = r_psel;
    w_penable_d   = r_penable;
    w_pwrite_d    = r_pwrite;
    w_paddr_d     = r_paddr;
    w_pwdata_d    = r_pwdata;

    case (r_state)
      StIdle: begin
        w_hreadyout_d = 1'b1;
        w_hresp_d     = HrespOkay;
        if (w_valid) begin
          w_addr_d      = bus.haddr;
          w_write_d     = bus.hwrite;
          w_hit_d       = w_dec_hit;
          w_idx_d       = w_dec_idx;
          w_hreadyout_d = 1'b0;
          w_state_d     = StLatch;
        end
      end

      StLatch: begin
        w_pwdata_d = bus.hwdata;
        if (r_hit) begin
          w_psel_d    = NUM_SLV'(1) << r_idx;
          w_penable_d = 1'b0;
          w_paddr_d   = r_addr;
          w_pwrite_d  = r_write;
          w_state_d   = StSetup;
        end else begin
`ifdef AHB2APB_SLVERR_EN
          w_hresp_d     = HrespErr;
          w_state_d     = StErr1;
`else
          // Miss completes as OKAY without touching the APB; reads return zero.
          w_hreadyout_d = 1'b1;
          if (!r_write) begin
            w_hrdata_d = '0;
          end
          w_state_d     = StIdle;
`endif
        end
      end

      StSetup: begin
        w_penable_d = 1'b1;
        w_state_d   = StAccess;
      end

      StAccess: begin
        if (w_sel_pready) begin
          w_psel_d    = '0;
          w_penable_d = 1'b0;
`ifdef AHB2APB_SLVERR_EN
          if (w_sel_pslverr) begin
            w_hresp_d = HrespErr;
            w_state_d = StErr1;
          end else begin
            w_hreadyout_d = 1'b1;
            if (!r_write) begin
              w_hrdata_d = w_sel_prdata;
            end
            w_state_d = StIdle;
          end
`else
          w_hreadyout_d = 1'b1;
          if (!r_write) begin
            w_hrdata_d = w_sel_prdata;
          end
          w_state_d = StIdle;
`endif
        end
      end

`ifdef AHB2APB_SLVERR_EN
      // Two-cycle AHB ERROR: hreadyout low then high with hresp held at ERROR.
      StErr1: begin
        w_hresp_d     = HrespErr;
        w_hreadyout_d = 1'b1;
        w_state_d     = StErr2;
      end

      StErr2: begin
        w_hresp_d     = HrespOkay;
        w_hreadyout_d = 1'b1;
        w_state_d     = StIdle;
      end
`endif

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HrespOkay;
      r_hrdata    <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_write     <= w_write_d;
      r_hit       <= w_hit_d;
      r_idx       <= w_idx_d;
      r_hreadyout <= w_hreadyout_d;
      r_hresp     <= w_hresp_d;
      r_hrdata    <= w_hrdata_d;
      r_psel      <= w_psel_d;
      r_penable   <= w_penable_d;
      r_pwrite    <= w_pwrite_d;
      r_paddr     <= w_paddr_d;
      r_pwdata    <= w_pwdata_d;
    end
  end

  assign bus.hreadyout = r_hreadyout;
  assign bus.hresp     = r_hresp;
  assign bus.hrdata    = r_hrdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;

  a_psel_onehot0: assert property (@(posedge i_hclk) disable iff (i_hreset) $onehot0(r_psel));
  a_penable_sel:  assert property (@(posedge i_hclk) disable iff (i_hreset) r_penable |-> |r_psel);

endmodule
